// File: rtl/one_hot_pkg.sv
// one_hot_pkg: shared state and control encodings for the one-hot sequencer.
package one_hot_pkg;
   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} seq_state_e;
   typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;
   typedef enum logic {MODE_ONEHOT = 1'b0, MODE_THERMO = 1'b1} mode_e;
endpackage

// File: rtl/one_hot_encoder.sv
// one_hot_encoder: gated binary-to-one-hot decode.
module one_hot_encoder #(
   parameter int OUTPUT_WIDTH = 16,
   parameter int INPUT_WIDTH  = $clog2(OUTPUT_WIDTH)
) (
   input  logic [INPUT_WIDTH-1:0]  value_i,
   input  logic                    en_i,
   output logic [OUTPUT_WIDTH-1:0] code_o
);
   always_comb
      for (int k = 0; k < OUTPUT_WIDTH; k++)
         code_o[k] = en_i && (value_i == INPUT_WIDTH'(k));
endmodule

// File: rtl/one_hot_sequencer.sv
// one_hot_sequencer: registered index with load/step/wrap control, presented
// as a gated one-hot or thermometer code with status flags.
module one_hot_sequencer
   import one_hot_pkg::*;
#(
   parameter int OUTPUT_WIDTH = 16,
   parameter int INPUT_WIDTH  = $clog2(OUTPUT_WIDTH)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    clear_i,
   input  logic                    load_i,
   input  logic [INPUT_WIDTH-1:0]  value_i,
   input  logic                    step_i,
   input  logic                    dir_i,
   input  logic                    wrap_en_i,
   input  logic                    mode_i,
   input  logic                    en_out_i,
   output logic [OUTPUT_WIDTH-1:0] code_o,
   output logic [INPUT_WIDTH-1:0]  index_o,
   output logic                    valid_o,
   output logic                    wrap_o,
   output logic                    sat_o,
   output logic                    err_o
);
   localparam logic [INPUT_WIDTH-1:0] MAX = INPUT_WIDTH'(OUTPUT_WIDTH - 1);
   seq_state_e                state;
   logic [INPUT_WIDTH-1:0]    index;
   logic                      wrap, sat, err;
   logic                      down, over, at_end, gate;
   logic [INPUT_WIDTH-1:0]    next, wrap_to;
   logic [OUTPUT_WIDTH-1:0]   onehot, thermo;
   assign down    = dir_i == DIR_DOWN;
   assign over    = value_i > MAX;
   assign at_end  = down ? index == '0 : index == MAX;
   assign next    = down ? index - 1'b1 : index + 1'b1;
   assign wrap_to = down ? MAX : '0;
   assign gate    = en_out_i && valid_o;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         state <= IDLE;
         index <= '0;
         wrap  <= 1'b0;
         sat   <= 1'b0;
         err   <= 1'b0;
      end else begin
         wrap <= 1'b0;
         err  <= 1'b0;
         if (clear_i) begin
            state <= IDLE;
            index <= '0;
            sat   <= 1'b0;
         end else if (load_i) begin
            state <= ACTIVE;
            index <= over ? MAX : value_i;
            err   <= over;
            sat   <= 1'b0;
         end else if (step_i && state == ACTIVE) begin
            // at an end the step either wraps (pulse) or is blocked (sticky sat)
            index <= at_end ? (wrap_en_i ? wrap_to : index) : next;
            wrap  <= at_end && wrap_en_i;
            sat   <= at_end && !wrap_en_i;
         end
      end
   one_hot_encoder #(.OUTPUT_WIDTH(OUTPUT_WIDTH), .INPUT_WIDTH(INPUT_WIDTH)) u_enc (
      .value_i(index),
      .en_i   (gate),
      .code_o (onehot)
   );
   always_comb
      for (int k = 0; k < OUTPUT_WIDTH; k++)
         thermo[k] = gate && (INPUT_WIDTH'(k) <= index);
   assign code_o  = mode_i == MODE_THERMO ? thermo : onehot;
   assign index_o = index;
   assign valid_o = state == ACTIVE;
   assign wrap_o  = wrap;
   assign sat_o   = sat;
   assign err_o   = err;
endmodule

// File: tb/tb_one_hot_sequencer.sv
// tb_one_hot_sequencer: directed and random checks of 16- and 10-wide
// sequencers against an integer reference model.
module tb_one_hot_sequencer;
   logic       clk = 1'b0;
   logic       rst_i, clear_i, load_i, step_i, dir_i, wrap_en_i, mode_i, en_out_i;
   logic [3:0] value_i;
   logic [15:0] code16;
   logic [9:0]  code10;
   logic [3:0]  idx16, idx10;
   logic        valid16, wrap16, sat16, err16;
   logic        valid10, wrap10, sat10, err10;
   int          checks = 0;
   int          failures = 0;
   int          wid[2] = '{16, 10};
   int          m_idx[2];
   bit          m_act[2], m_wrap[2], m_sat[2], m_err[2];
   logic [15:0] seen;

   always #5 clk = ~clk;

   one_hot_sequencer #(.OUTPUT_WIDTH(16)) dut16 (
      .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .load_i(load_i), .value_i(value_i),
      .step_i(step_i), .dir_i(dir_i), .wrap_en_i(wrap_en_i), .mode_i(mode_i),
      .en_out_i(en_out_i), .code_o(code16), .index_o(idx16), .valid_o(valid16),
      .wrap_o(wrap16), .sat_o(sat16), .err_o(err16));

   one_hot_sequencer #(.OUTPUT_WIDTH(10)) dut10 (
      .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .load_i(load_i), .value_i(value_i),
      .step_i(step_i), .dir_i(dir_i), .wrap_en_i(wrap_en_i), .mode_i(mode_i),
      .en_out_i(en_out_i), .code_o(code10), .index_o(idx10), .valid_o(valid10),
      .wrap_o(wrap10), .sat_o(sat10), .err_o(err10));

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int w = 0; w < 2; w++) begin
         m_idx[w] = 0; m_act[w] = 0; m_wrap[w] = 0; m_sat[w] = 0; m_err[w] = 0;
      end
   endtask

   task automatic model_step();
      for (int w = 0; w < 2; w++) begin
         int n;
         m_wrap[w] = 0;
         m_err[w]  = 0;
         if (clear_i) begin
            m_idx[w] = 0; m_act[w] = 0; m_sat[w] = 0;
         end else if (load_i) begin
            m_act[w] = 1;
            m_err[w] = int'(value_i) >= wid[w];
            m_idx[w] = m_err[w] ? wid[w] - 1 : int'(value_i);
            m_sat[w] = 0;
         end else if (step_i && m_act[w]) begin
            n = m_idx[w] + (dir_i ? -1 : 1);
            if (n >= 0 && n < wid[w]) begin
               m_idx[w] = n; m_sat[w] = 0;
            end else if (wrap_en_i) begin
               m_idx[w] = (n + wid[w]) % wid[w]; m_wrap[w] = 1; m_sat[w] = 0;
            end else
               m_sat[w] = 1;
         end
      end
   endtask

   function automatic logic [31:0] exp_code(int w);
      if (!m_act[w] || !en_out_i) return 32'd0;
      return mode_i ? (32'd1 << (m_idx[w] + 1)) - 32'd1 : 32'd1 << m_idx[w];
   endfunction

   task automatic check_all(string tag);
      chk({tag, "/16 index"}, 32'(idx16),   32'(m_idx[0]));
      chk({tag, "/16 code"},  32'(code16),  exp_code(0));
      chk({tag, "/16 valid"}, 32'(valid16), 32'(m_act[0]));
      chk({tag, "/16 wrap"},  32'(wrap16),  32'(m_wrap[0]));
      chk({tag, "/16 sat"},   32'(sat16),   32'(m_sat[0]));
      chk({tag, "/16 err"},   32'(err16),   32'(m_err[0]));
      chk({tag, "/10 index"}, 32'(idx10),   32'(m_idx[1]));
      chk({tag, "/10 code"},  32'(code10),  exp_code(1));
      chk({tag, "/10 valid"}, 32'(valid10), 32'(m_act[1]));
      chk({tag, "/10 wrap"},  32'(wrap10),  32'(m_wrap[1]));
      chk({tag, "/10 sat"},   32'(sat10),   32'(m_sat[1]));
      chk({tag, "/10 err"},   32'(err10),   32'(m_err[1]));
   endtask

   task automatic tick(string tag);
      @(posedge clk);
      model_step();
      #1;
      check_all(tag);
   endtask

   task automatic drive(bit c, bit l, int v, bit s, bit d, bit we);
      clear_i = c; load_i = l; value_i = 4'(v); step_i = s; dir_i = d; wrap_en_i = we;
   endtask

   initial begin
      rst_i = 1'b1; mode_i = 1'b0; en_out_i = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_i = 1'b0;
      check_all("reset");

      drive(0, 0, 0, 1, 0, 1);  tick("idle_step");
      drive(0, 1, 5, 0, 0, 0);  tick("load5");
      chk("load5 literal code", 32'(code16), 32'h0020);

      drive(0, 1, 15, 0, 0, 1); tick("load15");
      drive(0, 0, 0, 1, 0, 1);  tick("wrap_up");
      chk("wrap_up literal code", 32'(code16), 32'h0001);
      drive(0, 0, 0, 0, 0, 1);  tick("wrap_drop");

      drive(0, 1, 15, 0, 0, 0); tick("load15b");
      drive(0, 0, 0, 1, 0, 0);  tick("sat_up");
      drive(0, 0, 0, 0, 0, 0);  tick("sat_hold");
      drive(0, 0, 0, 1, 1, 0);  tick("sat_release");

      drive(0, 1, 0, 0, 0, 1);  tick("load0");
      drive(0, 0, 0, 1, 1, 1);  tick("wrap_down");
      seen = '0;
      for (int i = 0; i < 16; i++) begin
         tick("sweep");
         seen |= code16;
      end
      chk("sweep_cover", 32'(seen), 32'h0000FFFF);

      drive(0, 1, 3, 0, 0, 0);  mode_i = 1'b1; tick("thermo3");
      chk("thermo3 literal code", 32'(code16), 32'h000F);
      drive(0, 0, 0, 0, 0, 0);  en_out_i = 1'b0; #1 check_all("en_off");
      en_out_i = 1'b1; mode_i = 1'b0; #1 check_all("en_on");

      drive(0, 1, 12, 0, 0, 0); tick("load12");
      drive(0, 1, 7, 1, 0, 1);  tick("load_step");
      drive(0, 0, 0, 1, 0, 1);  tick("step_a");
      tick("step_b");

      #2 rst_i = 1'b1;
      model_reset();
      #1 check_all("async_rst");
      @(posedge clk);
      #1 rst_i = 1'b0;
      check_all("rst_release");

      drive(0, 1, 9, 0, 0, 0);  tick("load9");
      drive(1, 1, 4, 1, 0, 1);  tick("clear_load");
      drive(0, 0, 0, 1, 1, 1);  tick("idle_step2");

      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 19) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 15),
               $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
         mode_i   = 1'($urandom_range(0, 1));
         en_out_i = $urandom_range(0, 7) != 0;
         tick("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
